vliw_regfile_write_arbiter: RTL and testbench

//  Shares the single regfile write port (we3/a3/wd3) between the two IEU lanes of a VLIW STARBUG bundle.

---
 rtl/vliw_regfile_write_arbiter_if.sv | 33 +++
 rtl/vliw_regfile_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_vliw_regfile_write_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vliw_regfile_write_arbiter_if.sv
// Bundle of Writeback lane writes, regfile read-forwarding ports and the
// shared regfile write port handled by vliw_regfile_write_arbiter.
interface vliw_regfile_write_arbiter_if #(
  parameter int XLEN = 64
);
  logic            FlushW;
  logic            we0;
  logic            we1;
  logic [4:0]      a0;
  logic [4:0]      a1;
  logic [XLEN-1:0] wd0;
  logic [XLEN-1:0] wd1;
  logic [4:0]      ra  [4];
  logic [XLEN-1:0] rrf [4];
  logic [XLEN-1:0] rd  [4];
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic            ArbStallW;
  logic            Pending;

  // Writeback/hazard side: presents lane writes and raw read data.
  modport master (
    output FlushW, we0, we1, a0, a1, wd0, wd1, ra, rrf,
    input  rd, we3, a3, wd3, ArbStallW, Pending
  );

  // Arbiter side.
  modport slave (
    input  FlushW, we0, we1, a0, a1, wd0, wd1, ra, rrf,
    output rd, we3, a3, wd3, ArbStallW, Pending
  );
endinterface

// File: rtl/vliw_regfile_write_arbiter.sv
// Shares the single regfile write port between the two IEU lanes of a VLIW
// bundle. Lane 0 is older than lane 1. One write per cycle reaches the
// regfile; any extra accepted write waits in a small in-order FIFO whose
// contents are forwarded to the read ports until they retire.
module vliw_regfile_write_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input logic                         clk,
  input logic                         reset,
  vliw_regfile_write_arbiter_if.slave rfIf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]      fifoA [DEPTH];
  logic [XLEN-1:0] fifoD [DEPTH];
  logic [PW-1:0]   headPtr;
  logic [PW-1:0]   tailPtr;
  logic [PW-1:0]   tailPtrInc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   ageIdx [DEPTH];

  logic            stall;
  logic            fifoRetire;
  logic            lane0Ok;
  logic            lane1Ok;
  logic            push0;
  logic            push1;
  logic [4:0]      push0A;
  logic [4:0]      push1A;
  logic [XLEN-1:0] push0D;
  logic [XLEN-1:0] push1D;
  logic            we3Next;
  logic [4:0]      a3Next;
  logic [XLEN-1:0] wd3Next;
  logic [XLEN-1:0] rdNext [4];

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stall one entry before full: net growth is at most one per cycle.
  assign stall      = (count >= CW'(DEPTH - 1));
  // A non-empty FIFO always owns the write port; nothing retires in reset.
  assign fifoRetire = !reset && (count != '0);
  assign tailPtrInc = ptrInc(tailPtr);

  // Incoming filter: drop x0, ignore while stalled/flushed, coalesce a0==a1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    lane0Ok = 1'b0;
    lane1Ok = 1'b0;
    if (!reset && !stall && !rfIf.FlushW) begin
      lane0Ok = rfIf.we0 && (rfIf.a0 != 5'd0);
      lane1Ok = rfIf.we1 && (rfIf.a1 != 5'd0);
      if (lane0Ok && lane1Ok && (rfIf.a0 == rfIf.a1)) lane0Ok = 1'b0;
    end
  end

  // Port selection (FIFO head, lane 0, lane 1) and push of the leftovers.
  always_comb begin
    we3Next = 1'b0;
    a3Next  = '0;
    wd3Next = '0;
    push0   = 1'b0;
    push1   = 1'b0;
    push0A  = rfIf.a1;
    push0D  = rfIf.wd1;
    push1A  = rfIf.a1;
    push1D  = rfIf.wd1;
    if (fifoRetire) begin
      we3Next = 1'b1;
      a3Next  = fifoA[headPtr];
      wd3Next = fifoD[headPtr];
      if (lane0Ok) begin
        push0  = 1'b1;
        push0A = rfIf.a0;
        push0D = rfIf.wd0;
        push1  = lane1Ok;
      end else begin
        push0  = lane1Ok;
      end
    end else if (lane0Ok) begin
      we3Next = 1'b1;
      a3Next  = rfIf.a0;
      wd3Next = rfIf.wd0;
      push0   = lane1Ok;
    end else if (lane1Ok) begin
      we3Next = 1'b1;
      a3Next  = rfIf.a1;
      wd3Next = rfIf.wd1;
    end
  end

  // Physical slot of the i-th oldest FIFO entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(headPtr) + i >= DEPTH) ageIdx[i] = PW'(int'(headPtr) + i - DEPTH);
      else                            ageIdx[i] = PW'(int'(headPtr) + i);
    end
  end

  // Read forwarding: youngest live, non-retiring FIFO match wins over rrf.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rdNext[k] = rfIf.rrf[k];
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && !((i == 0) && fifoRetire) &&
            (fifoA[ageIdx[i]] == rfIf.ra[k]))
          rdNext[k] = fifoD[ageIdx[i]];
      end
      if (rfIf.ra[k] == 5'd0) rdNext[k] = '0;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (fifoRetire) headPtr <= ptrInc(headPtr);
      if (push1)      tailPtr <= ptrInc(tailPtrInc);
      else if (push0) tailPtr <= tailPtrInc;
      count <= count + CW'(push0) + CW'(push1) - CW'(fifoRetire);
    end
  end

  // FIFO payload writes at the tail.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; count and pointers alone decide which entries are live.
    if (push0) begin
      fifoA[tailPtr] <= push0A;
      fifoD[tailPtr] <= push0D;
    end
    if (push1) begin
      fifoA[tailPtrInc] <= push1A;
      fifoD[tailPtrInc] <= push1D;
    end
  end

  assign rfIf.we3       = we3Next;
  assign rfIf.a3        = a3Next;
  assign rfIf.wd3       = wd3Next;
  assign rfIf.rd        = rdNext;
  assign rfIf.ArbStallW = stall;
  assign rfIf.Pending   = (count != '0);

endmodule

// File: tb/tb_vliw_regfile_write_arbiter.sv
// Self-checking bench: two arbiters (DEPTH=2 and DEPTH=4) share stimulus;
// one at a time is compared against a queue-based reference model and a
// program-order golden regfile.
module tb_vliw_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vliw_regfile_write_arbiter_if #(.XLEN(64)) busA ();
  vliw_regfile_write_arbiter_if #(.XLEN(64)) busB ();

  vliw_regfile_write_arbiter #(.XLEN(64), .DEPTH(2)) dutA (
    .clk   (clk),
    .reset (reset),
    .rfIf  (busA)
  );

  vliw_regfile_write_arbiter #(.XLEN(64), .DEPTH(4)) dutB (
    .clk   (clk),
    .reset (reset),
    .rfIf  (busB)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // stimulus
  logic        sRst, sFlush, sWe0, sWe1;
  logic [4:0]  sA0, sA1;
  logic [63:0] sWd0, sWd1;
  logic [4:0]  sRa  [4];
  logic [63:0] sRrf [4];

  // selected DUT and its observed outputs
  int          sel      = 0;
  int          curDepth = 2;
  logic        oWe, oStall, oPend;
  logic [4:0]  oA3;
  logic [63:0] oWd3;
  logic [63:0] oRd [4];

  // reference model state
  wr_t         q[$];
  logic [63:0] goldRf [32];
  logic [63:0] actRf  [32];
  bit          lastTaken = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic setIdle();
    sRst = 1'b0; sFlush = 1'b0; sWe0 = 1'b0; sWe1 = 1'b0;
    sA0 = '0; sA1 = '0; sWd0 = '0; sWd1 = '0;
    for (int k = 0; k < 4; k++) begin
      sRa[k]  = '0;
      sRrf[k] = '0;
    end
  endtask

  task automatic setLanes(input logic we0, input logic [4:0] a0, input logic [63:0] wd0,
                          input logic we1, input logic [4:0] a1, input logic [63:0] wd1);
    sWe0 = we0; sA0 = a0; sWd0 = wd0;
    sWe1 = we1; sA1 = a1; sWd1 = wd1;
  endtask

  task automatic clearRf();
    for (int r = 0; r < 32; r++) begin
      goldRf[r] = '0;
      actRf[r]  = '0;
    end
  endtask

  // One clock cycle: drive after the edge, sample mid-cycle, compare, advance model.
  task automatic step();
    wr_t         acc[$];
    wr_t         all[$];
    logic        expStall, expWe, taken;
    logic [63:0] expRd;
    int          start;
    @(posedge clk);
    #1;
    reset = sRst;
    busA.FlushW = sFlush; busB.FlushW = sFlush;
    busA.we0 = sWe0; busB.we0 = sWe0; busA.we1 = sWe1; busB.we1 = sWe1;
    busA.a0  = sA0;  busB.a0  = sA0;  busA.a1  = sA1;  busB.a1  = sA1;
    busA.wd0 = sWd0; busB.wd0 = sWd0; busA.wd1 = sWd1; busB.wd1 = sWd1;
    for (int k = 0; k < 4; k++) begin
      busA.ra[k] = sRa[k]; busB.ra[k] = sRa[k];
      busA.rrf[k] = sRrf[k]; busB.rrf[k] = sRrf[k];
    end
    #3;
    cyc++;
    if (sel == 0) begin
      oWe = busA.we3; oA3 = busA.a3; oWd3 = busA.wd3; oStall = busA.ArbStallW; oPend = busA.Pending;
      for (int k = 0; k < 4; k++) oRd[k] = busA.rd[k];
    end else begin
      oWe = busB.we3; oA3 = busB.a3; oWd3 = busB.wd3; oStall = busB.ArbStallW; oPend = busB.Pending;
      for (int k = 0; k < 4; k++) oRd[k] = busB.rd[k];
    end

    expStall = (q.size() >= curDepth - 1);
    taken    = !sRst && !expStall && !sFlush;
    acc = {};
    if (taken) begin
      if (sWe0 && sA0 != 0 && !(sWe1 && sA1 == sA0)) acc.push_back('{a: sA0, d: sWd0});
      if (sWe1 && sA1 != 0) acc.push_back('{a: sA1, d: sWd1});
    end
    all = q;
    foreach (acc[i]) all.push_back(acc[i]);
    expWe = !sRst && (all.size() > 0);

    check("we3", 64'(oWe), 64'(expWe));
    if (expWe) begin
      check("a3", 64'(oA3), 64'(all[0].a));
      check("wd3", oWd3, all[0].d);
    end
    check("ArbStallW", 64'(oStall), 64'(expStall));
    check("Pending", 64'(oPend), 64'(q.size() != 0));

    start = (!sRst && q.size() > 0) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      expRd = sRrf[k];
      for (int i = start; i < q.size(); i++)
        if (q[i].a == sRa[k]) expRd = q[i].d;
      if (sRa[k] == 0) expRd = '0;
      check($sformatf("rd%0d", k), oRd[k], expRd);
    end

    // program-order golden regfile and regfile as written by the DUT
    if (taken) begin
      if (sWe0 && sA0 != 0) goldRf[sA0] = sWd0;
      if (sWe1 && sA1 != 0) goldRf[sA1] = sWd1;
    end
    if (oWe === 1'b1) actRf[oA3] = oWd3;

    if (sRst) q = {};
    else begin
      if (all.size() > 0) void'(all.pop_front());
      q = all;
    end
    lastTaken = taken;
  endtask

  task automatic randPhase(input int n);
    bit have = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!have || lastTaken) begin
        setLanes($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), {$urandom, $urandom});
        have = 1'b1;
      end
      sFlush = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 4; k++) begin
        sRa[k]  = 5'($urandom_range(0, 7));
        sRrf[k] = {$urandom, $urandom};
      end
      step();
    end
    setIdle();
    for (int c = 0; c < curDepth + 2; c++) step();
  endtask

  task automatic compareRf(input string tag);
    for (int r = 1; r < 32; r++) check($sformatf("%s.x%0d", tag, r), actRf[r], goldRf[r]);
  endtask

  initial begin
    wr_t burst [4];
    int  b;
    setIdle();
    clearRf();
    reset = 1'b1;
    sRst  = 1'b1;
    step();
    step();
    setIdle();

    // reset state
    step();
    check("rst.we3", 64'(oWe), 64'd0);
    check("rst.a3", 64'(oA3), 64'd0);
    check("rst.wd3", oWd3, 64'd0);
    check("rst.stall", 64'(oStall), 64'd0);
    check("rst.pend", 64'(oPend), 64'd0);

    // single write, zero latency
    setLanes(1, 5, 64'hAA, 0, 0, 0);
    step();
    check("single.we3", 64'(oWe), 64'd1);
    check("single.a3", 64'(oA3), 64'd5);
    check("single.wd3", oWd3, 64'hAA);
    check("single.pend", 64'(oPend), 64'd0);
    setIdle();
    step();
    check("single.pend2", 64'(oPend), 64'd0);

    // dual write: lane 0 now, lane 1 next cycle
    setLanes(1, 5, 64'h11, 1, 6, 64'h22);
    step();
    check("dual.a3c0", 64'(oA3), 64'd5);
    check("dual.wd3c0", oWd3, 64'h11);
    check("dual.pendc0", 64'(oPend), 64'd0);
    setIdle();
    step();
    check("dual.we3c1", 64'(oWe), 64'd1);
    check("dual.a3c1", 64'(oA3), 64'd6);
    check("dual.wd3c1", oWd3, 64'h22);
    check("dual.pendc1", 64'(oPend), 64'd1);
    check("dual.stallc1", 64'(oStall), 64'd1);
    step();
    check("dual.pendc2", 64'(oPend), 64'd0);

    // coalesce a0==a1: lane 1 wins, nothing buffered
    setLanes(1, 7, 64'h1, 1, 7, 64'h2);
    step();
    check("coal.a3", 64'(oA3), 64'd7);
    check("coal.wd3", oWd3, 64'h2);
    setIdle();
    step();
    check("coal.we3", 64'(oWe), 64'd0);
    check("coal.pend", 64'(oPend), 64'd0);

    // x0 write dropped
    setLanes(1, 0, 64'h5, 1, 9, 64'h99);
    step();
    check("x0.a3", 64'(oA3), 64'd9);
    check("x0.wd3", oWd3, 64'h99);
    setIdle();
    step();
    check("x0.pend", 64'(oPend), 64'd0);

    // flush: no write, no push
    setLanes(1, 3, 64'h33, 1, 4, 64'h44);
    sFlush = 1'b1;
    step();
    check("flush.we3", 64'(oWe), 64'd0);
    setIdle();
    step();
    check("flush.pend", 64'(oPend), 64'd0);

    // back-to-back dual writes with upstream hold while stalled
    burst[0] = '{a: 5'd10, d: 64'h100}; burst[1] = '{a: 5'd11, d: 64'h101};
    burst[2] = '{a: 5'd11, d: 64'h102}; burst[3] = '{a: 5'd12, d: 64'h103};
    b = 0;
    for (int c = 0; c < 24 && b < 4; c++) begin
      setLanes(1, burst[b].a, burst[b].d, 1, 5'(burst[b].a + 5'd3), burst[b].d + 64'h10);
      step();
      if (lastTaken) b++;
    end
    check("b2b.done", 64'(b), 64'd4);
    setIdle();
    for (int c = 0; c < 4; c++) step();
    compareRf("dirA");

    // randomized, DEPTH=2
    randPhase(1500);
    compareRf("randA");

    // switch to DEPTH=4 instance
    sRst = 1'b1;
    step();
    setIdle();
    clearRf();
    sel = 1;
    curDepth = 4;

    // forwarding from a non-retiring FIFO entry
    setLanes(1, 5, 64'h11, 1, 6, 64'h22);
    step();
    setLanes(1, 7, 64'h77, 1, 8, 64'h88);
    sRa[0] = 6; sRrf[0] = 64'h5A;
    step();
    check("fwd.retiringHead", oRd[0], 64'h5A);
    setIdle();
    sRa[0] = 8; sRrf[0] = 64'h0;
    sRa[1] = 7; sRrf[1] = 64'h33;
    sRa[2] = 0; sRrf[2] = 64'h77;
    step();
    check("fwd.x8", oRd[0], 64'h88);
    check("fwd.x7retiring", oRd[1], 64'h33);
    check("fwd.x0", oRd[2], 64'h0);
    sRa[0] = 8; sRrf[0] = 64'h44;
    step();
    check("fwd.afterRetire", oRd[0], 64'h44);
    setIdle();
    step();

    // randomized, DEPTH=4
    randPhase(1500);
    compareRf("randB");

    // reset mid-operation on DEPTH=2 instance
    sRst = 1'b1;
    step();
    setIdle();
    sel = 0;
    curDepth = 2;
    setLanes(1, 5, 64'h11, 1, 6, 64'h22);
    step();
    setIdle();
    sRst = 1'b1;
    step();
    check("midRst.we3", 64'(oWe), 64'd0);
    setIdle();
    step();
    check("midRst.pend", 64'(oPend), 64'd0);
    check("midRst.we3after", 64'(oWe), 64'd0);
    check("midRst.a3", 64'(oA3), 64'd0);
    check("midRst.wd3", oWd3, 64'd0);
    step();
    check("midRst.noStale", 64'(oWe), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
